// File: rtl/catc_pkg.sv
// ---------------------------------------------------------------------------
// catc_pkg
// Shared types and constants for the CATC memory-stall bridge:
//   catc_stall_state_t   : access sequencer states
//   STALL_BITS           : width of the saturating stall-cycle counter
//   TIMEOUT_DATA_DEFAULT : read value returned when the host never answers
//   sat_inc              : saturating increment for the stall counter
// ---------------------------------------------------------------------------
package catc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } catc_stall_state_t;

    localparam int STALL_BITS = 16;

    localparam logic [7:0] TIMEOUT_DATA_DEFAULT = 8'hFF;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [STALL_BITS-1:0] sat_inc(input logic [STALL_BITS-1:0] value);
        logic [STALL_BITS-1:0] result;
        if (value == {STALL_BITS{1'b1}}) begin
            result = value;
        end else begin
            result = value + STALL_BITS'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/catc_stall_timer.sv
// ---------------------------------------------------------------------------
// catc_stall_timer
// Latency timer for one outstanding host access.
//   Clk     in  : core clock
//   Reset   in  : asynchronous active-low reset
//   clear   in  : restart from zero (new access captured)
//   enable  in  : access is in flight, count this cycle
//   expire  out : registered, high during the MaxLatency-th enabled cycle
// The terminal count is registered one cycle early so that expire is a flop
// output yet still lines up with the MaxLatency-th cycle of the access.
// ---------------------------------------------------------------------------
module catc_stall_timer #(
    parameter int MaxLatency = 1024
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CntBits = $clog2(MaxLatency + 1);
    localparam logic [CntBits-1:0] PRE_TC  = CntBits'(MaxLatency - 2);
    localparam logic [CntBits-1:0] MAX_CNT = CntBits'(MaxLatency);

    logic [CntBits-1:0] count_r;

    // Count enabled cycles and flag the cycle on which the limit is reached.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count_r <= {CntBits{1'b0}};
            expire  <= 1'b0;
        end else if (clear) begin
            count_r <= {CntBits{1'b0}};
            expire  <= 1'b0;
        end else if (enable) begin
            if (count_r != MAX_CNT) begin
                count_r <= count_r + CntBits'(1);
            end else begin
                count_r <= count_r;
            end
            expire <= (count_r == PRE_TC);
        end else begin
            count_r <= count_r;
            expire  <= 1'b0;
        end
    end

endmodule

// File: rtl/catc_mem_stall.sv
// ---------------------------------------------------------------------------
// catc_mem_stall
// Bridges core memory requests (issued on CATC core ticks) to a
// variable-latency valid/ready host memory port, holding Delay high while the
// access is outstanding so the core freezes until the result is available.
//   Clk, Reset           : core clock, asynchronous active-low reset
//   CoreCe               : core tick enable (never high two cycles in a row)
//   CoreReq/We/Addr/WData: core access request, sampled on a tick in IDLE
//   CoreRData            : read data, held until the next completed read
//   MemValid/Ready/We/Addr/WData : host request channel
//   MemRValid/RData      : host read response channel
//   Delay                : to CATC, high while the core must not tick
//   Timeout              : sticky flag, set by any latency timeout
//   StallCycles          : saturating count of cycles with Delay high
// ---------------------------------------------------------------------------
module catc_mem_stall
    import catc_pkg::*;
#(
    parameter int                  AddrBits    = 24,
    parameter int                  DataBits    = 8,
    parameter int                  MaxLatency  = 1024,
    parameter logic [DataBits-1:0] TimeoutData = DataBits'(TIMEOUT_DATA_DEFAULT)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  CoreCe,
    input  logic                  CoreReq,
    input  logic                  CoreWe,
    input  logic [AddrBits-1:0]   CoreAddr,
    input  logic [DataBits-1:0]   CoreWData,
    output logic [DataBits-1:0]   CoreRData,
    output logic                  MemValid,
    input  logic                  MemReady,
    output logic                  MemWe,
    output logic [AddrBits-1:0]   MemAddr,
    output logic [DataBits-1:0]   MemWData,
    input  logic                  MemRValid,
    input  logic [DataBits-1:0]   MemRData,
    output logic                  Delay,
    output logic                  Timeout,
    output logic [STALL_BITS-1:0] StallCycles
);

    catc_stall_state_t state_r;
    logic              drain_r;
    logic              capture_s;
    logic              in_flight_s;
    logic              rvalid_ok_s;
    logic              expire_s;

    // A tick with a request is only honoured while idle.
    assign capture_s   = (state_r == IDLE) && CoreCe && CoreReq;
    assign in_flight_s = (state_r == ISSUE) || (state_r == WAIT);
    // While draining, the next response belongs to an abandoned read.
    assign rvalid_ok_s = MemRValid && !drain_r;

    catc_stall_timer #(
        .MaxLatency (MaxLatency)
    ) u_timer (
        .Clk    (Clk),
        .Reset  (Reset),
        .clear  (capture_s),
        .enable (in_flight_s),
        .expire (expire_s)
    );

    // Access sequencer: capture, host handshake, response/timeout, release.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r   <= IDLE;
            MemValid  <= 1'b0;
            MemWe     <= 1'b0;
            MemAddr   <= {AddrBits{1'b0}};
            MemWData  <= {DataBits{1'b0}};
            Delay     <= 1'b0;
            Timeout   <= 1'b0;
            CoreRData <= TimeoutData;
            drain_r   <= 1'b0;
        end else begin
            // Swallow the stale response of a timed-out read in any state;
            // a drain set further down in the same cycle takes precedence.
            if (drain_r && MemRValid) begin
                drain_r <= 1'b0;
            end else begin
                drain_r <= drain_r;
            end

            case (state_r)
                IDLE: begin
                    if (capture_s) begin
                        MemWe    <= CoreWe;
                        MemAddr  <= CoreAddr;
                        MemWData <= CoreWData;
                        MemValid <= 1'b1;
                        Delay    <= 1'b1;
                        state_r  <= ISSUE;
                    end else begin
                        state_r <= IDLE;
                    end
                end

                ISSUE: begin
                    if (MemReady) begin
                        MemValid <= 1'b0;
                        if (MemWe) begin
                            state_r <= DONE;
                        end else if (rvalid_ok_s) begin
                            // Same-cycle response: data wins over a timeout.
                            CoreRData <= MemRData;
                            state_r   <= DONE;
                        end else if (expire_s) begin
                            // Accepted but unanswered: its response is still coming.
                            CoreRData <= TimeoutData;
                            Timeout   <= 1'b1;
                            drain_r   <= 1'b1;
                            state_r   <= DONE;
                        end else begin
                            state_r <= WAIT;
                        end
                    end else if (expire_s) begin
                        // Never accepted: withdraw, nothing to drain.
                        MemValid <= 1'b0;
                        Timeout  <= 1'b1;
                        if (!MemWe) begin
                            CoreRData <= TimeoutData;
                        end else begin
                            CoreRData <= CoreRData;
                        end
                        state_r <= DONE;
                    end else begin
                        state_r <= ISSUE;
                    end
                end

                WAIT: begin
                    if (rvalid_ok_s) begin
                        CoreRData <= MemRData;
                        state_r   <= DONE;
                    end else if (expire_s) begin
                        CoreRData <= TimeoutData;
                        Timeout   <= 1'b1;
                        drain_r   <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        state_r <= WAIT;
                    end
                end

                DONE: begin
                    Delay   <= 1'b0;
                    state_r <= IDLE;
                end

                default: begin
                    MemValid <= 1'b0;
                    Delay    <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    // Saturating count of cycles the core spent frozen.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            StallCycles <= {STALL_BITS{1'b0}};
        end else if (Delay) begin
            StallCycles <= sat_inc(StallCycles);
        end else begin
            StallCycles <= StallCycles;
        end
    end

endmodule

// File: doc/catc_mem_stall.md
Name: catc_mem_stall

Overview:
- Upstream companion of the CATC clock-enable controller.
- Bridges core memory requests, issued on core ticks, to a variable-latency host memory port (SDRAM/cache) with a valid/ready handshake.
- Drives the CATC Delay input while an access is outstanding, so the core freezes. CATC later catches up the lost reference ticks.
- Also returns read data stable for the core, enforces a latency timeout, and counts stall cycles.

Parameters:
- AddrBits, 24, core/host address width.
- DataBits, 8, data width.
- MaxLatency, 1024, host cycles allowed in WAIT before timeout; must be ≥2.
- TimeoutData, 'hFF, read value returned on timeout (open bus).

Ports:
- Clk  in  1  FPGA core clock.
- Reset  in  1  asynchronous, active-low reset.
- CoreCe  in  1  core tick enable (CATC ClkEnOut); never high on two consecutive Clk cycles.
- CoreReq  in  1  core requests an access this tick.
- CoreWe  in  1  1=write, 0=read.
- CoreAddr  in  AddrBits  access address.
- CoreWData  in  DataBits  write data.
- CoreRData  out  DataBits  read data, held until the next accepted read completes.
- MemValid  out  1  host request valid.
- MemReady  in  1  host accepts request.
- MemWe  out  1  host write.
- MemAddr  out  AddrBits  host address.
- MemWData  out  DataBits  host write data.
- MemRValid  in  1  host read response valid.
- MemRData  in  DataBits  host read data.
- Delay  out  1  to CATC Delay; high while the core must not tick.
- Timeout  out  1  sticky; set on any timeout, cleared only by reset.
- StallCycles  out  16  saturating count of Clk cycles with Delay high.

Behaviour:
- Reset (Reset low, asynchronous) forces:
  - state IDLE, MemValid=0, MemWe=0, Delay=0, Timeout=0, StallCycles=0.
  - CoreRData=TimeoutData, MemAddr/MemWData=0, Drain=0.
- Capture: in IDLE, on a cycle with CoreCe=1 and CoreReq=1:
  - register CoreWe, CoreAddr and CoreWData onto the Mem* outputs.
  - next cycle: MemValid=1, Delay=1, state ISSUE.
  - Capture is therefore 1 Clk after the tick. The CoreCe gap guarantees CATC sees Delay before the next tick.
- CoreReq is ignored when CoreCe=0 and in every state other than IDLE.
- ISSUE:
  - Hold MemValid and Mem* stable until MemReady=1.
  - On the accept cycle, drop MemValid next cycle.
  - Write: go to DONE.
  - Read: go to WAIT. If MemRValid is also high in the same cycle, take the data and go to DONE directly.
- WAIT:
  - On MemRValid=1 (with Drain=0): CoreRData<=MemRData; go to DONE.
  - Timer counts cycles spent in ISSUE+WAIT. On reaching MaxLatency: CoreRData<=TimeoutData, Timeout<=1, MemValid<=0, and go to DONE.
  - If the request was already accepted when the timeout fires, set Drain=1.
- DONE:
  - Delay=0 next cycle; state returns to IDLE in the same transition.
  - Minimum stall is 3 Clk cycles (capture → ISSUE → DONE) for a zero-wait host.
- Drain: while Drain=1, the first MemRValid is discarded and clears Drain.
  - A new capture is allowed while draining, but its read response is only taken after Drain clears.
- Timer is cleared on every capture. Timeout in ISSUE (never accepted) withdraws the request, with no drain.
- StallCycles increments every cycle Delay=1 and saturates at 'hFFFF (no wrap).
- Simultaneous MemRValid and timeout on the same cycle: the data wins and there is no Timeout.
- Writes never report read data; CoreRData is unchanged by writes.
- Reset mid-access abandons the access. The host port must be reset by the same signal.

Decomposition:
- Package catc_pkg holds:
  - typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} catc_stall_state_t.
  - localparam for the StallCycles width (16).
  - default TimeoutData.
- One sub-module, catc_stall_timer:
  - clear/enable counter with terminal-count pulse at MaxLatency.
  - width $clog2(MaxLatency+1).

Test Plan:
- Read, zero-wait host (MemReady tied 1, MemRValid 1 cycle after accept, MemRData='h5A): Delay high exactly 3 cycles; CoreRData='h5A before the next CoreCe; StallCycles=3.
- Write with MemReady withheld 10 cycles: MemValid/MemAddr/MemWData stable all 10 cycles; Delay high 12 cycles; CoreRData unchanged.
- CoreReq=1 with CoreCe=0 for 20 cycles: MemValid stays 0, Delay stays 0.
- Read, host never responds, MaxLatency=16: after 16 cycles CoreRData='hFF, Timeout=1, Delay drops. A late MemRValid ('h33) is discarded; a following read returning 'h44 yields 'h44.
- Reset pulsed low mid-WAIT: all outputs return to reset values immediately (asynchronously); the next capture proceeds normally.
- 70000 back-to-back stalled cycles: StallCycles saturates at 'hFFFF.
